// File: rtl/riscv_sc_core.sv
// riscv_sc_core: single-cycle RV32I core with PC, 32x32 register file, decode, ALU and branch/jump logic
module riscv_sc_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] read_data,
  output logic        mem_write,
  output logic [31:0] pc,
  output logic [31:0] alu_result,
  output logic [31:0] write_data
);
  logic [31:0] regs [32];
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic        op_lui, op_auipc, op_jal, op_jalr, op_branch, op_load, op_store, op_imm, op_reg;
  logic        arith, alt, eq, lt, ltu, take, reg_write;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, src_a, src_b, pc_plus4, wb_data, next_pc;
  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign rd        = instr[11:7];
  assign rs1       = instr[19:15];
  assign rs2       = instr[24:20];
  assign op_lui    = opcode == 7'b0110111;
  assign op_auipc  = opcode == 7'b0010111;
  assign op_jal    = opcode == 7'b1101111;
  assign op_jalr   = opcode == 7'b1100111;
  assign op_branch = opcode == 7'b1100011;
  assign op_load   = opcode == 7'b0000011;
  assign op_store  = opcode == 7'b0100011;
  assign op_imm    = opcode == 7'b0010011;
  assign op_reg    = opcode == 7'b0110011;
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign rs1_val    = rs1 == 5'd0 ? 32'd0 : regs[rs1];
  assign rs2_val    = rs2 == 5'd0 ? 32'd0 : regs[rs2];
  assign write_data = rs2_val;
  assign mem_write  = op_store;
  assign src_a = op_lui ? 32'd0 : op_auipc ? pc : rs1_val;
  assign src_b = (op_reg | op_branch) ? rs2_val : op_store ? imm_s : (op_lui | op_auipc) ? imm_u : imm_i;
  assign arith = op_reg | op_imm;
  // ADDI must ignore bit 30, so only register ops or the shift-right funct3 honour it
  assign alt   = instr[30] & (op_reg | funct3 == 3'b101);
  always_comb begin
    alu_result = src_a + src_b;
    if (arith)
      case (funct3)
        3'b000:  alu_result = alt ? src_a - src_b : src_a + src_b;
        3'b001:  alu_result = src_a << src_b[4:0];
        3'b010:  alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
        3'b011:  alu_result = {31'd0, src_a < src_b};
        3'b100:  alu_result = src_a ^ src_b;
        3'b101:  alu_result = alt ? 32'($signed(src_a) >>> src_b[4:0]) : src_a >> src_b[4:0];
        3'b110:  alu_result = src_a | src_b;
        default: alu_result = src_a & src_b;
      endcase
  end
  assign eq   = rs1_val == rs2_val;
  assign lt   = $signed(rs1_val) < $signed(rs2_val);
  assign ltu  = rs1_val < rs2_val;
  assign take = op_branch & (funct3[2:1] == 2'b00 ? eq ^ funct3[0] :
                             funct3[2:1] == 2'b10 ? lt ^ funct3[0] :
                             funct3[2:1] == 2'b11 ? ltu ^ funct3[0] : 1'b0);
  assign pc_plus4  = pc + 32'd4;
  assign next_pc   = op_jalr ? {alu_result[31:1], 1'b0} : op_jal ? pc + imm_j : take ? pc + imm_b : pc_plus4;
  assign reg_write = (arith | op_lui | op_auipc | op_load | op_jal | op_jalr) & (rd != 5'd0);
  assign wb_data   = op_load ? read_data : (op_jal | op_jalr) ? pc_plus4 : alu_result;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc <= 32'd0;
      for (int k = 0; k < 32; k++) regs[k] <= 32'd0;
    end else begin
      pc <= next_pc;
      if (reg_write) regs[rd] <= wb_data;
    end
endmodule

// File: tb/tb_riscv_sc_core.sv
// tb_riscv_sc_core: table-driven program check with scoreboard queue plus async-reset sequences
module tb_riscv_sc_core;
  logic        clk = 0, reset = 1, mem_write;
  logic [31:0] instr, read_data, pc, alu_result, write_data;
  logic [31:0] dmem [16];
  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0] instr, pc, alu, wd, npc;
    logic        mw, ca, cw;
  } vec_t;
  vec_t tv[$];
  vec_t sb[$];

  riscv_sc_core dut (.clk(clk), .reset(reset), .instr(instr), .read_data(read_data),
                     .mem_write(mem_write), .pc(pc), .alu_result(alu_result), .write_data(write_data));

  always #5 clk = ~clk;
  assign read_data = dmem[alu_result[5:2]];
  always @(posedge clk) if (mem_write) dmem[alu_result[5:2]] <= write_data;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    logic [11:0] im = imm[11:0];
    return {im, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input logic [4:0] rs2, rs1);
    logic [11:0] im = imm[11:0];
    return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2, rs1, input logic [2:0] f3);
    logic [12:0] im = imm[12:0];
    return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
    logic [20:0] im = imm[20:0];
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
  endfunction

  function automatic vec_t mk(input logic [31:0] i, p, n, input logic m, ca, input logic [31:0] a, input logic cw, input logic [31:0] w);
    vec_t v;
    v.instr = i; v.pc = p; v.npc = n; v.mw = m; v.ca = ca; v.alu = a; v.cw = cw; v.wd = w;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  localparam logic [6:0] OPI = 7'b0010011;

  initial begin
    for (int k = 0; k < 16; k++) dmem[k] = 32'd0;
    instr = enc_i(0, 0, 3'b000, 0, OPI);
    // instr, pc, next pc, mem_write, check alu, alu, check wd, wd
    tv.push_back(mk(enc_i(5, 0, 0, 1, OPI),                 32'h00, 32'h04, 0, 1, 32'h5, 0, 0));
    tv.push_back(mk(enc_i(-3, 0, 0, 2, OPI),                32'h04, 32'h08, 0, 1, 32'hFFFFFFFD, 0, 0));
    tv.push_back(mk(enc_r(7'h00, 2, 1, 3'b000, 3),          32'h08, 32'h0C, 0, 1, 32'h2, 0, 0));
    tv.push_back(mk(enc_s(8, 3, 0),                         32'h0C, 32'h10, 1, 1, 32'h8, 1, 32'h2));
    tv.push_back(mk(enc_b(8, 1, 1, 3'b000),                 32'h10, 32'h18, 0, 0, 0, 1, 32'h5));
    tv.push_back(mk(enc_b(8, 1, 1, 3'b001),                 32'h18, 32'h1C, 0, 0, 0, 0, 0));
    tv.push_back(mk(enc_r(7'h20, 1, 2, 3'b000, 4),          32'h1C, 32'h20, 0, 1, 32'hFFFFFFF8, 0, 0));
    tv.push_back(mk(enc_j(12, 1),                           32'h20, 32'h2C, 0, 0, 0, 0, 0));
    tv.push_back(mk(enc_r(7'h00, 0, 1, 3'b000, 0),          32'h2C, 32'h30, 0, 1, 32'h24, 0, 0));
    tv.push_back(mk(enc_i(0, 1, 0, 0, 7'b1100111),          32'h30, 32'h24, 0, 1, 32'h24, 0, 0));
    tv.push_back(mk(enc_r(7'h00, 1, 2, 3'b010, 4),          32'h24, 32'h28, 0, 1, 32'h1, 0, 0));
    tv.push_back(mk(enc_r(7'h00, 1, 2, 3'b011, 4),          32'h28, 32'h2C, 0, 1, 32'h0, 0, 0));
    tv.push_back(mk(enc_i(32'h401, 2, 3'b101, 4, OPI),      32'h2C, 32'h30, 0, 1, 32'hFFFFFFFE, 0, 0));
    tv.push_back(mk(enc_i(1, 0, 0, 8, OPI),                 32'h30, 32'h34, 0, 1, 32'h1, 0, 0));
    tv.push_back(mk(enc_r(7'h20, 8, 2, 3'b101, 4),          32'h34, 32'h38, 0, 1, 32'hFFFFFFFE, 0, 0));
    tv.push_back(mk(enc_r(7'h00, 8, 2, 3'b101, 4),          32'h38, 32'h3C, 0, 1, 32'h7FFFFFFE, 0, 0));
    tv.push_back(mk({20'h12345, 5'd5, 7'b0110111},          32'h3C, 32'h40, 0, 1, 32'h12345000, 0, 0));
    tv.push_back(mk({20'h00001, 5'd6, 7'b0010111},          32'h40, 32'h44, 0, 1, 32'h1040, 0, 0));
    tv.push_back(mk(enc_i(7, 0, 0, 0, OPI),                 32'h44, 32'h48, 0, 1, 32'h7, 0, 0));
    tv.push_back(mk(enc_s(12, 0, 0),                        32'h48, 32'h4C, 1, 1, 32'hC, 1, 32'h0));
    tv.push_back(mk(enc_i(8, 0, 3'b010, 7, 7'b0000011),     32'h4C, 32'h50, 0, 1, 32'h8, 0, 0));
    tv.push_back(mk(enc_s(16, 7, 0),                        32'h50, 32'h54, 1, 1, 32'h10, 1, 32'h2));
    tv.push_back(mk(enc_r(7'h00, 6, 5, 3'b000, 0),          32'h54, 32'h58, 0, 1, 32'h12346040, 0, 0));
    tv.push_back(mk(enc_i(1, 3, 0, 3, OPI),                 32'h58, 32'h5C, 0, 1, 32'h3, 0, 0));
    tv.push_back(mk(enc_r(7'h00, 0, 3, 3'b000, 0),          32'h5C, 32'h60, 0, 1, 32'h3, 0, 0));
    tv.push_back(mk(32'h0000018B,                           32'h60, 32'h64, 0, 0, 0, 0, 0));
    tv.push_back(mk(enc_r(7'h00, 0, 3, 3'b000, 0),          32'h64, 32'h68, 0, 1, 32'h3, 0, 0));
    tv.push_back(mk(enc_b(-8, 1, 2, 3'b100),                32'h68, 32'h60, 0, 0, 0, 0, 0));
    tv.push_back(mk(enc_b(16, 1, 2, 3'b110),                32'h60, 32'h64, 0, 0, 0, 0, 0));
    tv.push_back(mk(enc_b(16, 2, 1, 3'b101),                32'h64, 32'h74, 0, 0, 0, 0, 0));
    tv.push_back(mk(enc_i(-1, 2, 3'b100, 9, OPI),           32'h74, 32'h78, 0, 1, 32'h2, 0, 0));
    tv.push_back(mk(enc_i(32'hF0, 2, 3'b111, 9, OPI),       32'h78, 32'h7C, 0, 1, 32'hF0, 0, 0));
    tv.push_back(mk(enc_i(3, 1, 3'b001, 9, OPI),            32'h7C, 32'h80, 0, 1, 32'h120, 0, 0));
    tv.push_back(mk(enc_i(-1, 1, 3'b011, 9, OPI),           32'h80, 32'h84, 0, 1, 32'h1, 0, 0));
    tv.push_back(mk(enc_i(32'h400, 0, 0, 9, OPI),           32'h84, 32'h88, 0, 1, 32'h400, 0, 0));
    tv.push_back(mk(enc_b(16, 2, 1, 3'b111),                32'h88, 32'h8C, 0, 0, 0, 0, 0));

    #12;
    chk("reset_pc", pc, 32'h0);
    chk("reset_mem_write", {31'd0, mem_write}, 32'h0);
    #8;
    @(posedge clk); #1;
    reset = 0;

    foreach (tv[n]) begin
      vec_t e;
      instr = tv[n].instr;
      sb.push_back(tv[n]);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("pc[%0d]", n), pc, e.pc);
      chk($sformatf("mem_write[%0d]", n), {31'd0, mem_write}, {31'd0, e.mw});
      if (e.ca) chk($sformatf("alu[%0d]", n), alu_result, e.alu);
      if (e.cw) chk($sformatf("wdata[%0d]", n), write_data, e.wd);
      @(posedge clk); #1;
      chk($sformatf("next_pc[%0d]", n), pc, e.npc);
    end

    // asynchronous reset mid-program, between clock edges
    instr = enc_i(9, 0, 0, 1, OPI);
    #2 reset = 1;
    #1 chk("async_pc", pc, 32'h0);
    instr = enc_r(7'h00, 0, 1, 3'b000, 0);
    #1 chk("async_x1_clear", alu_result, 32'h0);
    instr = enc_s(8, 5, 0);
    #1 chk("reset_store_decode", {31'd0, mem_write}, 32'h1);
    chk("async_x5_clear", write_data, 32'h0);
    instr = enc_i(9, 0, 0, 1, OPI);
    @(posedge clk); #1;
    chk("reset_hold_pc", pc, 32'h0);
    reset = 0;
    instr = enc_r(7'h00, 0, 1, 3'b000, 0);
    @(negedge clk);
    chk("no_write_in_reset", alu_result, 32'h0);
    @(posedge clk); #1;
    chk("first_pc_after_release", pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
